// File: rtl/shiftreg_prog.sv
// Programmable delay line (1..MAX_SHIFT enabled cycles) with per-stage valid tracking.
// Outputs tap register outputs only; ce=0 freezes every stage, flush/cfg_we drop all in-flight tokens.
module shiftreg_prog #(
    parameter int DATA          = 32,
    parameter int MAX_SHIFT     = 32,
    parameter int DEFAULT_SHIFT = 1,
    localparam int DW           = $clog2(MAX_SHIFT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic [DATA-1:0] data_in,
    input  logic            valid_in,
    input  logic            flush,
    input  logic            cfg_we,
    input  logic [DW-1:0]   delay_sel,
    output logic [DATA-1:0] data_out,
    output logic            valid_out,
    output logic [DW-1:0]   delay_q,
    output logic [DW-1:0]   in_flight,
    output logic            empty
);

    localparam int AW = (MAX_SHIFT > 1) ? $clog2(MAX_SHIFT) : 1;
    localparam logic [DW-1:0] LP_MAX = DW'(MAX_SHIFT);
    localparam logic [DW-1:0] LP_DEF = DW'(DEFAULT_SHIFT);

    logic [DATA-1:0]      r_stage [MAX_SHIFT];
    logic [MAX_SHIFT-1:0] r_vstage;
    logic [DW-1:0]        r_dly;
    logic [DW-1:0]        r_cnt;

    logic [AW-1:0]        w_tap;
    logic [DW-1:0]        w_sel_clamp;
    logic                 w_clear;
    logic                 w_vout;

    assign w_tap   = AW'(r_dly - DW'(1));
    assign w_clear = flush | cfg_we;
    assign w_vout  = r_vstage[w_tap];

    always_comb begin
        w_sel_clamp = delay_sel;
        if (delay_sel == '0) begin
            w_sel_clamp = DW'(1);
        end else if (delay_sel > LP_MAX) begin
            w_sel_clamp = LP_MAX;
        end
    end

    // Count only tracks stages below the tap; clears wipe every valid bit so a later
    // delay change never exposes stale tokens beyond the old tap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_SHIFT; k++) begin
                r_stage[k] <= '0;
            end
            r_vstage <= '0;
            r_dly    <= LP_DEF;
            r_cnt    <= '0;
        end else if (w_clear) begin
            r_vstage <= '0;
            r_cnt    <= '0;
            if (cfg_we) begin
                r_dly <= w_sel_clamp;
            end
        end else if (ce) begin
            r_stage[0]  <= data_in;
            r_vstage[0] <= valid_in;
            for (int k = 1; k < MAX_SHIFT; k++) begin
                r_stage[k]  <= r_stage[k-1];
                r_vstage[k] <= r_vstage[k-1];
            end
            r_cnt <= r_cnt + DW'(valid_in) - DW'(w_vout);
        end
    end

    assign data_out  = r_stage[w_tap];
    assign valid_out = w_vout;
    assign delay_q   = r_dly;
    assign in_flight = r_cnt;
    assign empty     = (r_cnt == '0);

endmodule

// File: tb/tb_shiftreg_prog.sv
// Directed self-checking bench for shiftreg_prog (DATA=32, MAX_SHIFT=32, DEFAULT_SHIFT=1).
module tb_shiftreg_prog;

    localparam int DATA = 32;
    localparam int MAX_SHIFT = 32;
    localparam int DEFAULT_SHIFT = 1;
    localparam int DW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            ce;
    logic [DATA-1:0] data_in;
    logic            valid_in;
    logic            flush;
    logic            cfg_we;
    logic [DW-1:0]   delay_sel;
    logic [DATA-1:0] data_out;
    logic            valid_out;
    logic [DW-1:0]   delay_q;
    logic [DW-1:0]   in_flight;
    logic            empty;

    int n_checks = 0;
    int n_fail   = 0;

    shiftreg_prog #(
        .DATA(DATA),
        .MAX_SHIFT(MAX_SHIFT),
        .DEFAULT_SHIFT(DEFAULT_SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .data_in(data_in),
        .valid_in(valid_in),
        .flush(flush),
        .cfg_we(cfg_we),
        .delay_sel(delay_sel),
        .data_out(data_out),
        .valid_out(valid_out),
        .delay_q(delay_q),
        .in_flight(in_flight),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [DW-1:0] d);
        cfg_we    = 1'b1;
        delay_sel = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    logic vin_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic vout_pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   fl_pat [6] = '{1, 1, 2, 1, 1, 0};

    initial begin
        reset = 1'b1; ce = 1'b0; valid_in = 1'b0; flush = 1'b0;
        cfg_we = 1'b0; data_in = '0; delay_sel = '0;
        #12;
        check_eq("rst_data", data_out, 0);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_delay", delay_q, DEFAULT_SHIFT);
        check_eq("rst_inflight", in_flight, 0);
        check_eq("rst_empty", empty, 1);
        tick();
        reset = 1'b0;

        // delay 1 streaming
        ce = 1'b1; valid_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data_in = DATA'(i);
            tick();
            check_eq("d1_data", data_out, i);
            check_eq("d1_valid", valid_out, 1);
            check_eq("d1_inflight", in_flight, 1);
        end

        // maximum delay
        valid_in = 1'b0;
        cfg(6'd32);
        check_eq("max_delay", delay_q, 32);
        check_eq("max_cfg_inflight", in_flight, 0);
        check_eq("max_cfg_valid", valid_out, 0);
        valid_in = 1'b1;
        for (int i = 0; i < 36; i++) begin
            data_in = DATA'(32'hA0 + i);
            tick();
            check_eq("max_valid", valid_out, (i >= 31) ? 1 : 0);
            check_eq("max_inflight", in_flight, (i < 31) ? i + 1 : 32);
            if (i >= 31) check_eq("max_data", data_out, 32'hA0 + i - 31);
        end

        // stall with delay 4, stages preloaded with known data
        valid_in = 1'b0;
        cfg(6'd4);
        for (int i = 1; i <= 4; i++) begin
            data_in = DATA'(i);
            tick();
        end
        data_in = 32'h11; valid_in = 1'b1;
        tick();
        check_eq("st_e1_data", data_out, 32'h02);
        check_eq("st_e1_inflight", in_flight, 1);
        ce = 1'b0; data_in = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("st_hold_data", data_out, 32'h02);
            check_eq("st_hold_valid", valid_out, 0);
            check_eq("st_hold_inflight", in_flight, 1);
        end
        ce = 1'b1; data_in = 32'h22;
        tick();
        check_eq("st_e5_data", data_out, 32'h03);
        check_eq("st_e5_inflight", in_flight, 2);
        valid_in = 1'b0; data_in = '0;
        tick();
        check_eq("st_e6_data", data_out, 32'h04);
        check_eq("st_e6_valid", valid_out, 0);
        tick();
        check_eq("st_e7_data", data_out, 32'h11);
        check_eq("st_e7_valid", valid_out, 1);
        check_eq("st_e7_inflight", in_flight, 2);
        tick();
        check_eq("st_e8_data", data_out, 32'h22);
        check_eq("st_e8_valid", valid_out, 1);
        check_eq("st_e8_inflight", in_flight, 1);
        tick();
        check_eq("st_e9_valid", valid_out, 0);
        check_eq("st_e9_empty", empty, 1);

        // flush mid-stream at delay 8
        cfg(6'd8);
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = DATA'(32'h50 + i);
            tick();
        end
        check_eq("fl_pre_inflight", in_flight, 5);
        flush = 1'b1; data_in = 32'hEE;
        tick();
        flush = 1'b0; valid_in = 1'b0; data_in = '0;
        check_eq("fl_inflight", in_flight, 0);
        check_eq("fl_empty", empty, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("fl_no_valid", valid_out, 0);
            check_eq("fl_stay_empty", empty, 1);
        end

        // clamp and bubbles
        cfg(6'd0);
        check_eq("clamp_lo", delay_q, 1);
        cfg(6'd40);
        check_eq("clamp_hi", delay_q, 32);
        cfg(6'd3);
        check_eq("set_3", delay_q, 3);
        for (int i = 0; i < 6; i++) begin
            valid_in = vin_pat[i];
            data_in  = DATA'(32'h61 + i);
            tick();
            check_eq("bub_valid", valid_out, vout_pat[i]);
            check_eq("bub_inflight", in_flight, fl_pat[i]);
            if (vout_pat[i]) check_eq("bub_data", data_out, 32'h61 + i - 2);
        end

        // async reset between edges
        valid_in = 1'b1; data_in = 32'h77;
        tick();
        tick();
        check_eq("ar_pre_inflight", in_flight, 2);
        #2;
        reset = 1'b1;
        #2;
        check_eq("ar_data", data_out, 0);
        check_eq("ar_valid", valid_out, 0);
        check_eq("ar_delay", delay_q, DEFAULT_SHIFT);
        check_eq("ar_inflight", in_flight, 0);
        check_eq("ar_empty", empty, 1);
        reset = 1'b0;
        valid_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shiftreg_prog.md
# shiftreg_prog

Runtime-programmable, stallable delay line with valid tracking, replacing fixed-latency delay lines in the multiplier datapath where alignment latency depends on mode or the pipeline can stall. It delays `data_in` and `valid_in` by a programmable number of enabled clock cycles, from 1 to `MAX_SHIFT`. It supports pipeline stall via `ce` and flush of in-flight tokens. It reports the in-flight token count so control logic can drain the line before reconfiguring it.

## Interface
- `DATA`, default 32: data width in bits.
- `MAX_SHIFT`, default 32: number of storage stages and maximum delay; must be ≥ 1.
- `DEFAULT_SHIFT`, default 1: delay after reset; must be in 1..`MAX_SHIFT`.
- `DW`, derived, equals $clog2(`MAX_SHIFT`+1): width of the delay and count fields.

Ports:
- `clk` — in, 1: single clock; all state updates on its rising edge.
- `reset` — in, 1: asynchronous, active-high reset.
- `ce` — in, 1: shift enable; while low, all stages hold.
- `data_in` — in, `DATA`: input word.
- `valid_in` — in, 1: qualifies `data_in`; sampled only when `ce`=1.
- `flush` — in, 1: synchronous clear of all valid stages.
- `cfg_we` — in, 1: load a new delay from `delay_sel`.
- `delay_sel` — in, `DW`: requested delay.
- `data_out` — out, `DATA`: tap of stage `dly_q`-1.
- `valid_out` — out, 1: valid tap of stage `dly_q`-1.
- `delay_q` — out, `DW`: currently active delay.
- `in_flight` — out, `DW`: number of valid tokens in stages 0..`dly_q`-1.
- `empty` — out, 1: high when `in_flight`=0.

## Operation
- Storage is a data array `stage[0..MAX_SHIFT-1]` plus a parallel valid array `vstage`.
- Shift (`ce`=1, no `flush`, no `cfg_we`):
  - `stage[0]` ← `data_in`; `stage[k]` ← `stage[k-1]`.
  - `vstage` shifts identically, with `valid_in` entering at `vstage[0]`.
- Output taps:
  - `data_out` = `stage[dly_q-1]` and `valid_out` = `vstage[dly_q-1]`.
  - The tap mux sits on register outputs only; there is no combinational path from any input to any output.
  - `data_out` is not gated by valid.
- `flush`:
  - All `vstage` bits clear and `in_flight` goes to 0.
  - Data stages are untouched, and no shift occurs that cycle, so a `valid_in` presented that cycle is dropped.
- `cfg_we`:
  - `dly_q` ← `delay_sel`, clamped: 0→1, values above `MAX_SHIFT` → `MAX_SHIFT`.
  - It also clears valids exactly as `flush` does, with no shift that cycle.
- Priority: `reset` > `cfg_we` ≡ `flush` (both clear) > `ce` shift > hold.
- `in_flight` counter:
  - When `ce`=1 with no clear, it changes by +`valid_in` −`valid_out`; simultaneous entry and exit leaves it unchanged.
  - It never exceeds `dly_q`.
  - Stages at index ≥ `dly_q` are ignored by both outputs and the count.

## Timing
- Reset values:
  - All `stage` = 0 and all `vstage` = 0.
  - `dly_q` = `DEFAULT_SHIFT`, `in_flight` = 0, `empty` = 1.
  - Outputs are therefore `data_out` = 0, `valid_out` = 0, `delay_q` = `DEFAULT_SHIFT`.
- Latency:
  - A word sampled at edge N with `ce`=1 appears on `data_out` after the edge at which the `dly_q`-th enabled shift completes.
  - With `ce` held high, that is `dly_q` cycles, the same as a chain of `dly_q` registers.
- Stall: cycles with `ce`=0 add exactly one cycle of latency each; outputs are stable throughout the stall.
- A new delay takes effect on the output from the cycle after `cfg_we`. The first valid output after reconfiguration appears `new delay` enabled cycles after the first post-config `valid_in`.
- Reset asserted mid-stream returns every register to its reset value immediately. Tokens in flight are lost.
- Throughput is one word per enabled cycle, with no bubbles.

## Test plan
- Reset then delay 1: `ce`=1, `valid_in`=1, `data_in`=1,2,3… → `data_out`=1 on the cycle after the first input, valid contiguous, `in_flight` stays 1.
- Reconfigure to the maximum: `cfg_we` with `delay_sel`=`MAX_SHIFT`(32), then stream 0xA0..0xBF → first `valid_out` exactly 32 cycles later. `in_flight` ramps to 32 and holds, and stays 32 while streaming continues.
- Stall: delay 4, inputs 0x11,0x22 with `ce` low for 3 cycles between them → 0x11 appears at cycle 4, and 0x22 appears 3 cycles later than the unstalled timing. Outputs are frozen during the stall.
- Flush mid-stream: delay 8, 5 tokens in flight, assert `flush` together with `valid_in`=1 → `in_flight`=0 and `empty`=1 next cycle. No `valid_out` occurs for the next 8 enabled cycles, and the input presented with `flush` is never output.
- Clamp and bubbles: `delay_sel`=0 → `delay_q`=1; `delay_sel`=40 → `delay_q`=32. With delay 3 and the valid pattern 1,0,1 in, the same pattern comes out 3 cycles later and `in_flight` tracks 1,1,2,1,1,0.
- Async reset mid-stream: assert `reset` between edges → all outputs go to their reset values before the next edge, and `delay_q` returns to `DEFAULT_SHIFT`.
